fir_xifu_wb: RTL
================

FIR_XIFU_WB -- requirements
Module: fir_xifu_wb

Interface
REQ-001 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port clear_i  input  1  synchronous flush.
REQ-004 SHALL have ports valid_i input 1, ready_o output 1: EX/WB handshake; an entry is accepted when both are 1.
REQ-005 SHALL have entry ports instr_i input 2 (0=NONE, 1=XFIRLW, 2=XFIRSW, 3=XFIRDOTP), id_i input 4, rs1_i input 5, rd_i input 5, result_i input 32 (post-increment address for LW/SW, dot-product for DOTP).
REQ-006 SHALL have ports mem_valid_i input 1, mem_id_i input 4, mem_rdata_i input 32: core LSU memory result.
REQ-007 SHALL have ports commit_i input 16, kill_i input 16: sticky per-id commit and kill flags from the controller.
REQ-008 SHALL have ports rf_we_o output 1, rf_waddr_o output 5, rf_wdata_o output 32: XIFU register-file write.
REQ-009 SHALL have ports result_valid_o output 1, result_ready_i input 1, result_id_o output 4, result_rd_o output 5, result_we_o output 1, result_data_o output 32: core result interface.
REQ-010 SHALL have ports fwd_we_o output 1, fwd_rd_o output 5, fwd_result_o output 32: forwarding to EX.

Function
REQ-011 SHALL implement FSM states IDLE, MEM, COMMIT, RES; ready_o = 1 only in IDLE.
REQ-012 IDLE: on valid_i with instr_i != NONE, SHALL latch instr/id/rs1/rd/result into a holding register; LW/SW -> MEM, DOTP -> COMMIT; valid_i with NONE is accepted and dropped.
REQ-013 MEM: SHALL wait for mem_valid_i with mem_id_i == held id, latch mem_rdata_i, then -> COMMIT; memory results with another id SHALL be ignored.
REQ-014 COMMIT: if kill_i[id] = 1 SHALL go to IDLE with no rf write and no result; kill takes priority over a simultaneous commit.
REQ-015 COMMIT: if commit_i[id] = 1 and kill_i[id] = 0, SHALL pulse rf_we_o for exactly that cycle (LW: waddr=rd, wdata=latched rdata; DOTP: waddr=rd, wdata=held result; SW: no write), then -> RES.
REQ-016 COMMIT with neither flag set SHALL hold state with no outputs asserted other than forwarding.
REQ-017 RES: result_valid_o = 1 with result_id_o = id; LW/SW: result_we_o = 1, result_rd_o = rs1, result_data_o = held result (post-increment); DOTP: result_we_o = 0, result_rd_o = 0, result_data_o = 0.
REQ-018 RES SHALL hold all result outputs stable until result_ready_i = 1, then -> IDLE.
REQ-019 fwd_we_o SHALL be 1 in MEM, COMMIT and RES when the held instr is LW or SW, with fwd_rd_o = rs1 and fwd_result_o = held result; otherwise all forwarding outputs SHALL be 0.
REQ-020 Exactly one core result SHALL be produced per committed non-NONE instruction; none for killed ones.
REQ-021 Minimum occupancy SHALL be 3 cycles for DOTP (IDLE, COMMIT, RES), 4 for LW/SW with a same-cycle memory result.
REQ-022 clear_i SHALL force IDLE and zero the holding register on the next edge, overriding all other transitions, including mid-RES; no further rf write or result for the flushed entry.
REQ-023 Outputs other than those specified SHALL be 0; no output SHALL be X while out of reset.

Reset
REQ-024 While rst_ni = 0: state IDLE, holding register 0, rf_we_o = 0, result_valid_o = 0, fwd_we_o = 0, all data outputs 0, ready_o = 1 after release.
REQ-025 Reset asserted mid-operation SHALL abandon the held entry without any write or result.

Verification
REQ-026 DOTP id=3 rd=7 result=0x0000_0102, commit_i[3]=1 -> rf_we_o pulse one cycle, waddr=7, wdata=0x102; then result_valid_o with id=3, we=0.
REQ-027 LW id=5 rs1=10 rd=2 result=0x1000_0004, mem_valid_i id=5 rdata=0xCAFE_F00D two cycles later, commit set -> rf write rd=2 0xCAFEF00D; result rd=10 data=0x10000004 we=1; fwd_we_o=1 rd=10 throughout.
REQ-028 SW id=1 with mem result id=2 first, then id=1 -> MEM ignores id=2, exits only on id=1; no rf write; result we=1.
REQ-029 DOTP id=4 with commit_i[4] and kill_i[4] set simultaneously -> no rf write, no result, IDLE next cycle.
REQ-030 LW in RES with result_ready_i=0 for 5 cycles -> outputs stable; clear_i asserted -> IDLE next cycle, result_valid_o=0, ready_o=1.

Source files
------------

// File: rtl/fir_xifu_wb.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_wb
// Purpose  : Writeback stage of the FIR extension unit. Holds a single
//            offloaded instruction (XFIRLW / XFIRSW / XFIRDOTP) from EX,
//            waits for its memory result (loads/stores), waits for the
//            controller's commit or kill verdict, performs the XIFU
//            register-file write and hands one result to the core.
// Ports    : clk_i, rst_ni (async, active-low), clear_i (sync flush)
//            valid_i/ready_o + instr_i/id_i/rs1_i/rd_i/result_i : EX entry
//            mem_valid_i/mem_id_i/mem_rdata_i                    : LSU result
//            commit_i/kill_i                                     : per-id flags
//            rf_we_o/rf_waddr_o/rf_wdata_o                       : XIFU RF write
//            result_*                                            : core result
//            fwd_we_o/fwd_rd_o/fwd_result_o                      : EX forwarding
// Revision : 1.0 - initial release
// ============================================================================
module fir_xifu_wb (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  instr_i,
  input  logic [3:0]  id_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] result_i,
  input  logic        mem_valid_i,
  input  logic [3:0]  mem_id_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [15:0] commit_i,
  input  logic [15:0] kill_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [3:0]  result_id_o,
  output logic [4:0]  result_rd_o,
  output logic        result_we_o,
  output logic [31:0] result_data_o,
  output logic        fwd_we_o,
  output logic [4:0]  fwd_rd_o,
  output logic [31:0] fwd_result_o
);

  localparam logic [1:0] c_instr_none = 2'd0;
  localparam logic [1:0] c_instr_lw   = 2'd1;
  localparam logic [1:0] c_instr_sw   = 2'd2;
  localparam logic [1:0] c_instr_dotp = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM    = 2'd1,
    COMMIT = 2'd2,
    RES    = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  // Holding register for the in-flight entry
  logic [1:0]  r_instr;
  logic [3:0]  r_id;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic [31:0] r_rdata;

  logic        w_is_ls;
  logic        w_commit;
  logic        w_kill;
  logic        w_mem_hit;
  logic        w_capture;

  assign w_is_ls   = (r_instr == c_instr_lw) || (r_instr == c_instr_sw);
  assign w_commit  = commit_i[r_id];
  assign w_kill    = kill_i[r_id];
  assign w_mem_hit = mem_valid_i && (mem_id_i == r_id);
  // NONE entries are handshaken but never occupy the stage
  assign w_capture = (r_state == IDLE) && valid_i && (instr_i != c_instr_none);

  // State register: clear_i overrides every transition
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else if (clear_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instr  <= c_instr_none;
      r_id     <= 4'd0;
      r_rs1    <= 5'd0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
      r_rdata  <= 32'd0;
    end else if (clear_i) begin
      r_instr  <= c_instr_none;
      r_id     <= 4'd0;
      r_rs1    <= 5'd0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_capture) begin
        r_instr  <= instr_i;
        r_id     <= id_i;
        r_rs1    <= rs1_i;
        r_rd     <= rd_i;
        r_result <= result_i;
        r_rdata  <= 32'd0;
      end
      if ((r_state == MEM) && w_mem_hit) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_next   = r_state;
    ready_o        = 1'b0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = 5'd0;
    rf_wdata_o     = 32'd0;
    result_valid_o = 1'b0;
    result_id_o    = 4'd0;
    result_rd_o    = 5'd0;
    result_we_o    = 1'b0;
    result_data_o  = 32'd0;
    fwd_we_o       = 1'b0;
    fwd_rd_o       = 5'd0;
    fwd_result_o   = 32'd0;

    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (w_capture) begin
          w_state_next = (instr_i == c_instr_dotp) ? COMMIT : MEM;
        end
      end
      MEM: begin
        if (w_mem_hit) begin
          w_state_next = COMMIT;
        end
      end
      COMMIT: begin
        // Kill wins over a simultaneous commit
        if (w_kill) begin
          w_state_next = IDLE;
        end else if (w_commit) begin
          w_state_next = RES;
          // A flush in the same cycle suppresses the write for this entry
          if ((r_instr != c_instr_sw) && !clear_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = r_rd;
            rf_wdata_o = (r_instr == c_instr_lw) ? r_rdata : r_result;
          end
        end
      end
      RES: begin
        if (!clear_i) begin
          result_valid_o = 1'b1;
          result_id_o    = r_id;
          if (w_is_ls) begin
            result_we_o   = 1'b1;
            result_rd_o   = r_rs1;
            result_data_o = r_result;
          end
        end
        if (result_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Post-increment address stays visible to EX while the entry is held
    if ((r_state != IDLE) && w_is_ls) begin
      fwd_we_o     = 1'b1;
      fwd_rd_o     = r_rs1;
      fwd_result_o = r_result;
    end
  end

endmodule
`default_nettype wire
